// File: rtl/mii_tx_arbiter.sv
// Round-robin owner of the MII transmit port for two nibble-stream sources.
// Adds preamble/SFD, spaces frames by the IFG, truncates oversize frames and abandons frames that underrun.
module mii_tx_arbiter #(
  parameter int PRE_NIBBLES = 15,
  parameter int IFG_NIBBLES = 24,
  parameter int MAX_NIBBLES = 3036,
  parameter int CNT_W       = 12
) (
  input  logic       rxc,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] s0_data,
  input  logic [3:0] s1_data,
  input  logic       s0_vld,
  input  logic       s1_vld,
  input  logic       s0_last,
  input  logic       s1_last,
  output logic       s0_rd,
  output logic       s1_rd,
  output logic       gnt0,
  output logic       gnt1,
  output logic       txen,
  output logic [3:0] txd,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DRAIN, IFG} state_e;

  localparam logic [CNT_W-1:0] PRE_END = CNT_W'(PRE_NIBBLES - 2);
  localparam logic [CNT_W-1:0] IFG_END = CNT_W'(IFG_NIBBLES - 1);
  localparam logic [CNT_W-1:0] MAX_END = CNT_W'(MAX_NIBBLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             last_q, last_d;
  logic             txen_q, txen_d;
  logic [3:0]       txd_q, txd_d;
  logic             err_q, err_d;

  logic             xfer;
  logic             head_vld;
  logic             head_last;
  logic [3:0]       head_data;

  assign xfer      = (state_q == DATA) || (state_q == DRAIN);
  assign head_vld  = (gnt_q[0] & s0_vld) | (gnt_q[1] & s1_vld);
  assign head_last = (gnt_q[0] & s0_last) | (gnt_q[1] & s1_last);
  assign head_data = gnt_q[1] ? s1_data : s0_data;

  assign s0_rd = xfer & gnt_q[0] & s0_vld;
  assign s1_rd = xfer & gnt_q[1] & s1_vld;
  assign gnt0  = gnt_q[0];
  assign gnt1  = gnt_q[1];
  assign txen  = txen_q;
  assign txd   = txd_q;
  assign busy  = (state_q != IDLE);
  assign err   = err_q;

  always_ff @(posedge rxc or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      txen_q  <= 1'b0;
      txd_q   <= 4'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      txen_q  <= txen_d;
      txd_q   <= txd_d;
      err_q   <= err_d;
    end
  end

  // The state decides what the pins show on the following cycle, so the
  // pins run one cycle behind it (SFD state is the last preamble nibble).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    txen_d  = 1'b0;
    txd_d   = 4'h0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          if (req0 && (!req1 || last_q)) begin
            gnt_d  = 2'b01;
            last_d = 1'b0;
          end else begin
            gnt_d  = 2'b10;
            last_d = 1'b1;
          end
          state_d = (PRE_NIBBLES > 1) ? PRE : SFD;
          cnt_d   = '0;
          txen_d  = 1'b1;
          txd_d   = 4'h5;
        end
      end
      PRE: begin
        txen_d = 1'b1;
        txd_d  = 4'h5;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == PRE_END) begin
          state_d = SFD;
        end
      end
      SFD: begin
        txen_d  = 1'b1;
        txd_d   = 4'hD;
        cnt_d   = '0;
        state_d = DATA;
      end
      DATA: begin
        if (head_vld) begin
          txen_d = 1'b1;
          txd_d  = head_data;
          cnt_d  = cnt_q + CNT_W'(1);
          if (head_last) begin
            state_d = IFG;
            gnt_d   = 2'b00;
            cnt_d   = '0;
          end else if (cnt_q == MAX_END) begin
            state_d = DRAIN;
            err_d   = 1'b1;
          end
        end else begin
          state_d = DRAIN;
          err_d   = 1'b1;
        end
      end
      DRAIN: begin
        if (head_vld && head_last) begin
          state_d = IFG;
          gnt_d   = 2'b00;
          cnt_d   = '0;
        end
      end
      IFG: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == IFG_END) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
